// File: rtl/dsp_mac_sequencer_if.sv
// Control/sequencing bundle between the filter control FSM (master) and the
// DSP48A1 MAC sequencer (slave).
//
// Handshake: start is a request sampled by the sequencer only while busy=0
// (IDLE); taps is captured on that same cycle. While busy=1 start and taps
// are ignored. done is a one-cycle completion pulse. abort cancels a run in
// progress and is ignored while idle or in the done cycle.
interface dsp_mac_sequencer_if #(
  parameter int TAP_W = 4
);
  logic             start;
  logic [TAP_W-1:0] taps;
  logic             abort;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [TAP_W-1:0] rd_addr;
  logic             ce_ab;
  logic             ce_m;
  logic             ce_p;
  logic [7:0]       opmode;

  modport master (
    output start, taps, abort,
    input  busy, done, rd_en, rd_addr, ce_ab, ce_m, ce_p, opmode
  );

  modport slave (
    input  start, taps, abort,
    output busy, done, rd_en, rd_addr, ce_ab, ce_m, ce_p, opmode
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP48A1 slice through an N-tap multiply-accumulate.
// Operand reads are issued in ISSUE; a {valid, first} tag rides a shift
// register alongside each read so the A/B, M and P clock enables and OPMODE
// line up with the operand as it moves through memory latency and the
// slice's A/B -> M -> P registers.
module dsp_mac_sequencer #(
  parameter int TAP_W   = 4,
  parameter int MEM_LAT = 1   // 1..4 cycles from rd_en to operand at A/B
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active-low
  dsp_mac_sequencer_if.slave bus,
  output logic [1:0]         state_dbg
);

  localparam int               DEPTH     = MEM_LAT + 2;
  localparam logic [7:0]       OPM_FIRST = 8'h01;  // X=M, Z=0: start a new sum
  localparam logic [7:0]       OPM_ACC   = 8'h09;  // X=M, Z=P: accumulate
  localparam logic [7:0]       OPM_NONE  = 8'h00;
  localparam logic [TAP_W-1:0] ONE       = TAP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [TAP_W-1:0] count_q, count_d;
  logic [TAP_W-1:0] n_q, n_d;
  // Tag pipe, index 1 is the stage loaded by the read just issued.
  logic [DEPTH:1]   tag_vld_q, tag_vld_d;
  logic [DEPTH:1]   tag_first_q, tag_first_d;
  logic             rd_en;
  logic             flush;
  logic             zero_run;

  assign rd_en     = (state_q == S_ISSUE);
  assign state_dbg = state_q;

  // Next-state, tap count capture and read address counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    n_d     = n_q;
    flush   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d = bus.taps;
          if (bus.taps != '0) begin
            state_d = S_ISSUE;
            count_d = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        // Abort freezes the address so rd_addr keeps its last issued value.
        if (bus.abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (count_q == n_q - ONE) begin
          state_d = S_DRAIN;
        end else begin
          count_d = count_q + ONE;
        end
      end
      S_DRAIN: begin
        // Leave when only the P stage still holds a tag: that last ce_p
        // happens this cycle, so done lands one cycle after it.
        if (bus.abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (tag_vld_q[DEPTH-1:1] == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tag pipe shift; an abort drops every tag in flight.
  always_comb begin
    tag_vld_d   = {tag_vld_q[DEPTH-1:1], rd_en};
    tag_first_d = {tag_first_q[DEPTH-1:1], (count_q == '0)};
    if (flush) begin
      tag_vld_d   = '0;
      tag_first_d = '0;
    end
  end

  // Output decode: enables come straight from the tag pipe stages.
  always_comb begin
    zero_run    = (state_q == S_DONE) && (n_q == '0);
    bus.busy    = (state_q != S_IDLE);
    bus.done    = (state_q == S_DONE);
    bus.rd_en   = rd_en;
    bus.rd_addr = count_q;
    bus.ce_ab   = tag_vld_q[MEM_LAT];
    bus.ce_m    = tag_vld_q[MEM_LAT+1];
    // A zero-tap run clocks P once with OPMODE 0 so P reads back as 0.
    bus.ce_p    = tag_vld_q[DEPTH] | zero_run;
    bus.opmode  = OPM_NONE;
    if (tag_vld_q[DEPTH]) begin
      bus.opmode = tag_first_q[DEPTH] ? OPM_FIRST : OPM_ACC;
    end
  end

  // State, counters and tag pipe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      n_q         <= '0;
      tag_vld_q   <= '0;
      tag_first_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      n_q         <= n_d;
      tag_vld_q   <= tag_vld_d;
      tag_first_q <= tag_first_d;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: two instances (MEM_LAT=1 and MEM_LAT=3) share
// one stimulus stream. A run-level model predicts every output per cycle
// from the start cycle, tap count and latency; directed literal checks pin
// latencies, enable counts and the accumulated P of a stand-in datapath.
module tb_dsp_mac_sequencer;

  localparam int NDUT = 2;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic       ce_ab;
    logic       ce_m;
    logic       ce_p;
    logic [7:0] opmode;
  } obs_t;

  typedef struct packed {
    bit active;
    int s;      // cycle in which the accepted start was presented
    int n;
    int addr;   // rd_addr holds its last issued value
  } model_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic       start;
  logic [3:0] taps;
  logic       abort;
  logic [1:0] dbg1, dbg3;

  dsp_mac_sequencer_if #(.TAP_W(4)) bus1 ();
  dsp_mac_sequencer_if #(.TAP_W(4)) bus3 ();

  assign bus1.start = start;
  assign bus1.taps  = taps;
  assign bus1.abort = abort;
  assign bus3.start = start;
  assign bus3.taps  = taps;
  assign bus3.abort = abort;

  dsp_mac_sequencer #(.TAP_W(4), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(dbg1)
  );
  dsp_mac_sequencer #(.TAP_W(4), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .state_dbg(dbg3)
  );

  obs_t o [NDUT];
  always_comb begin
    o[0] = {bus1.busy, bus1.done, bus1.rd_en, bus1.rd_addr,
            bus1.ce_ab, bus1.ce_m, bus1.ce_p, bus1.opmode};
    o[1] = {bus3.busy, bus3.done, bus3.rd_en, bus3.rd_addr,
            bus3.ce_ab, bus3.ce_m, bus3.ce_p, bus3.opmode};
  end

  // ---------------- scoreboard state ----------------
  int     n_vec;
  int     n_miss;
  int     lat_tab [NDUT] = '{1, 3};
  model_t m [NDUT];
  int     p [NDUT];          // stand-in P register, A*B = 2 per tap
  int     p_done [NDUT];
  int     done_cyc [NDUT];
  int     done_cnt [NDUT];
  int     ce_p_cnt [NDUT];
  int     c0;

  function automatic int end_k(input int n, input int l);
    return (n == 0) ? 1 : n + l + 3;
  endfunction

  task automatic chk(input string name, input int i, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s lat%0d cyc=%0d actual=%0h required=%0h",
               name, lat_tab[i], cyc, act, exp);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Expected outputs for cycle k of a run (k=1 is the first cycle after the
  // accepting edge): reads in 1..N, ce_ab L cycles later, ce_m one more,
  // ce_p one more, done one cycle after the last ce_p.
  task automatic model_exp(input int i, output obs_t e);
    int k, n, l;
    e = '0;
    l = lat_tab[i];
    if (m[i].active) begin
      k = cyc - m[i].s;
      n = m[i].n;
      if (n == 0) begin
        if (k == 1) begin
          e.busy = 1'b1;
          e.done = 1'b1;
          e.ce_p = 1'b1;
        end
      end else begin
        e.busy  = (k >= 1 && k <= n + l + 3);
        e.done  = (k == n + l + 3);
        e.rd_en = (k >= 1 && k <= n);
        if (e.rd_en) m[i].addr = k - 1;
        e.ce_ab = (k >= 1 + l && k <= n + l);
        e.ce_m  = (k >= 2 + l && k <= n + l + 1);
        e.ce_p  = (k >= 3 + l && k <= n + l + 2);
        if (e.ce_p) e.opmode = (k == 3 + l) ? 8'h01 : 8'h09;
      end
    end
    e.rd_addr = m[i].addr[3:0];
  endtask

  // ---------------- compare process ----------------
  initial begin
    obs_t e;
    int   k, ek;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        for (int i = 0; i < NDUT; i++) begin
          if (!rst) begin
            m[i] = '0;
            p[i] = 0;
          end
          model_exp(i, e);
          chk("busy",    i, 8'(o[i].busy),    8'(e.busy));
          chk("done",    i, 8'(o[i].done),    8'(e.done));
          chk("rd_en",   i, 8'(o[i].rd_en),   8'(e.rd_en));
          chk("rd_addr", i, 8'(o[i].rd_addr), 8'(e.rd_addr));
          chk("ce_ab",   i, 8'(o[i].ce_ab),   8'(e.ce_ab));
          chk("ce_m",    i, 8'(o[i].ce_m),    8'(e.ce_m));
          chk("ce_p",    i, 8'(o[i].ce_p),    8'(e.ce_p));
          chk("opmode",  i, o[i].opmode,      e.opmode);
          // Stand-in datapath driven by the DUT's own enables.
          if (o[i].ce_p === 1'b1) begin
            ce_p_cnt[i]++;
            p[i] = ((o[i].opmode == 8'h09) ? p[i] : 0) +
                   ((o[i].opmode == 8'h01 || o[i].opmode == 8'h09) ? 2 : 0);
          end
          if (o[i].done === 1'b1) begin
            done_cnt[i]++;
            done_cyc[i] = cyc;
            p_done[i]   = p[i];
          end
          // Advance the model using the inputs the next edge will sample.
          if (rst) begin
            k  = cyc - m[i].s;
            ek = end_k(m[i].n, lat_tab[i]);
            if (m[i].active && (k >= ek || (abort && k < ek))) m[i].active = 1'b0;
            if (!e.busy && start) begin
              m[i].active = 1'b1;
              m[i].s      = cyc;
              m[i].n      = int'(taps);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_start(input int t);
    start = 1'b1;
    taps  = 4'(t);
    c0    = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int w;
    w = 0;
    while ((bus1.busy !== 1'b0 || bus3.busy !== 1'b0) && w < budget) begin
      tick(1);
      w++;
    end
    n_vec++;
    if (bus1.busy !== 1'b0 || bus3.busy !== 1'b0) begin
      n_miss++;
      $display("FAIL %s timeout actual=busy required=idle", name);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NDUT; i++) begin
      done_cnt[i] = 0;
      ce_p_cnt[i] = 0;
      done_cyc[i] = -1;
      p_done[i]   = -1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b0;
    start = 1'b0;
    taps  = 4'd0;
    abort = 1'b0;
    c0    = 0;
    clear_counts();
    tick(3);
    rst = 1'b1;
    tick(2);

    // Basic run, taps=3.
    clear_counts();
    run_start(3);
    wait_idle("t2", 40);
    lit("t2_lat_l1", done_cyc[0] - c0, 7);
    lit("t2_lat_l3", done_cyc[1] - c0, 9);
    lit("t2_p_l1", p_done[0], 6);
    lit("t2_p_l3", p_done[1], 6);
    lit("t2_cep_l1", ce_p_cnt[0], 3);
    tick(2);

    // Zero taps: a single DONE cycle.
    clear_counts();
    run_start(0);
    wait_idle("t3", 5);
    lit("t3_lat_l1", done_cyc[0] - c0, 1);
    lit("t3_lat_l3", done_cyc[1] - c0, 1);
    lit("t3_cep_l3", ce_p_cnt[1], 1);
    tick(2);

    // Abort in cycle 2 of a taps=4 run, then immediate restart.
    clear_counts();
    run_start(4);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(6);
    lit("t4_cep_l1", ce_p_cnt[0], 0);
    lit("t4_cep_l3", ce_p_cnt[1], 0);
    lit("t4_done_l1", done_cnt[0], 0);
    lit("t4_done_l3", done_cnt[1], 0);
    run_start(2);
    wait_idle("t4b", 40);
    lit("t4_restart_lat_l1", done_cyc[0] - c0, 6);
    lit("t4_restart_lat_l3", done_cyc[1] - c0, 8);
    lit("t4_restart_p_l1", p_done[0], 4);
    tick(2);

    // Reset held 3 cycles in the middle of a taps=5 run.
    clear_counts();
    run_start(5);
    tick(1);
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(8);
    lit("t1_cep_l1", ce_p_cnt[0], 0);
    lit("t1_cep_l3", ce_p_cnt[1], 0);
    lit("t1_done_l1", done_cnt[0], 0);

    // Start pulsed during a run, then held so each DUT restarts back to back.
    clear_counts();
    for (int j = 0; j < 20; j++) begin
      start = (j < 7) ? ((j % 2) == 0) : 1'b1;
      taps  = (j >= 2 && j <= 6) ? 4'd9 : 4'd3;
      tick(1);
    end
    start = 1'b0;
    taps  = 4'd3;
    wait_idle("t5", 60);
    lit("t5_done_l1", done_cnt[0], 3);
    lit("t5_done_l3", done_cnt[1], 2);
    lit("t5_cep_l1", ce_p_cnt[0], 9);
    tick(2);

    // Full-length run, taps=15.
    clear_counts();
    run_start(15);
    wait_idle("t6", 60);
    lit("t6_lat_l1", done_cyc[0] - c0, 19);
    lit("t6_lat_l3", done_cyc[1] - c0, 21);
    lit("t6_cep_l1", ce_p_cnt[0], 15);
    lit("t6_cep_l3", ce_p_cnt[1], 15);
    lit("t6_p_l3", p_done[1], 30);
    tick(2);

    // start and abort together while idle: start wins.
    clear_counts();
    abort = 1'b1;
    run_start(2);
    abort = 1'b0;
    wait_idle("t7", 40);
    lit("t7_lat_l1", done_cyc[0] - c0, 6);
    lit("t7_lat_l3", done_cyc[1] - c0, 8);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    n_miss++;
    $display("FAIL watchdog actual=running required=finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
